// File: rtl/ram_access_ctrl_if.sv
// Request/response handshake between the datapath and ram_access_ctrl.
// The datapath uses the master modport and the controller uses the slave modport.
interface ram_access_ctrl_if #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
);
  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic                  req_indirect;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_rdata;
  logic                  busy;

  modport master (
    output req_valid, req_we, req_indirect, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, busy
  );

  modport slave (
    input  req_valid, req_we, req_indirect, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, busy
  );
endinterface

// File: rtl/ram_access_ctrl.sv
// Bus initiator for the single-port ram. It turns valid/ready requests into
// direct or pointer-indirect RAM read/write cycles and owns the data bus on its side.
module ram_access_ctrl #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  ram_access_ctrl_if.slave      req_if,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  inout  wire  [DATA_WIDTH-1:0] mem_data,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic                  mem_oe
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PTR  = 3'd1,
    TURN = 3'd2,
    WR   = 3'd3,
    RD   = 3'd4,
    RESP = 3'd5
  } state_t;

  state_t                state_q, state_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [ADDR_WIDTH-1:0] target_q, target_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0] ptr_ext;

  // A pointer word fetched from memory becomes a full-width target address.
  generate
    if (DATA_WIDTH >= ADDR_WIDTH) begin : g_ptr_trunc
      assign ptr_ext = mem_data[ADDR_WIDTH-1:0];
    end else begin : g_ptr_zext
      assign ptr_ext = {{(ADDR_WIDTH-DATA_WIDTH){1'b0}}, mem_data};
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      we_q     <= 1'b0;
      addr_q   <= '0;
      target_q <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
    end else begin
      state_q  <= state_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      target_q <= target_d;
      wdata_q  <= wdata_d;
      rdata_q  <= rdata_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    we_d     = we_q;
    addr_d   = addr_q;
    target_d = target_q;
    wdata_d  = wdata_q;
    rdata_d  = rdata_q;
    case (state_q)
      IDLE: begin
        if (req_if.req_valid) begin
          we_d     = req_if.req_we;
          addr_d   = req_if.req_addr;
          target_d = req_if.req_addr;
          wdata_d  = req_if.req_wdata;
          if (req_if.req_indirect) begin
            state_d = PTR;
          end else if (req_if.req_we) begin
            state_d = WR;
          end else begin
            state_d = RD;
          end
        end
      end
      PTR: begin
        target_d = ptr_ext;
        // A write after a pointer fetch needs a dead cycle before we drive the bus.
        state_d  = we_q ? TURN : RD;
      end
      TURN: state_d = WR;
      WR: begin
        rdata_d = '0;
        state_d = RESP;
      end
      RD: begin
        rdata_d = mem_data;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_cs   = 1'b0;
    mem_we   = 1'b0;
    mem_oe   = 1'b0;
    mem_addr = '0;
    case (state_q)
      PTR: begin
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = addr_q;
      end
      WR: begin
        mem_cs   = 1'b1;
        mem_we   = 1'b1;
        mem_addr = target_q;
      end
      RD: begin
        mem_cs   = 1'b1;
        mem_oe   = 1'b1;
        mem_addr = target_q;
      end
      default: begin
        mem_cs   = 1'b0;
        mem_addr = '0;
      end
    endcase
  end

  assign mem_data         = (state_q == WR) ? wdata_q : 'z;
  assign req_if.req_ready = (state_q == IDLE);
  assign req_if.busy      = (state_q != IDLE);
  assign req_if.rsp_valid = (state_q == RESP);
  assign req_if.rsp_rdata = rdata_q;

endmodule
